// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: opcode encoding and flag bit positions.
// Opcodes 0-7 keep the legacy 3-bit ALU encoding so old microcode maps straight across.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_DEC   = 4'd2,
    OP_INC   = 4'd3,
    OP_NOT   = 4'd4,
    OP_AND   = 4'd5,
    OP_OR    = 4'd6,
    OP_XOR   = 4'd7,
    OP_SHL   = 4'd8,
    OP_SHR   = 4'd9,
    OP_SAR   = 4'd10,
    OP_ROL   = 4'd11,
    OP_ROR   = 4'd12,
    OP_PASSB = 4'd13,
    OP_NEG   = 4'd14,
    OP_CMP   = 4'd15
  } alu_op_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_core.sv
// Purely combinational result and {N,Z,C,V} calculator for the ALU pipeline.
// Define ALU_SAT_EN to clamp ADD/SUB/INC/DEC/NEG overflow to the signed limits.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  alu_op_e          i_op,
  output logic [WIDTH-1:0] o_result,
  output logic [3:0]       o_flags
);

  localparam int              MSB  = WIDTH - 1;
  localparam int              SW   = $clog2(WIDTH);
  localparam logic [SW-1:0]   W_LO = SW'(WIDTH);

  logic [SW-1:0]    w_amt;
  logic [SW-1:0]    w_rot;
  logic [WIDTH-1:0] w_x;
  logic [WIDTH-1:0] w_y;
  logic             w_cin;
  logic [WIDTH:0]   w_sum;
  logic             w_ovf;
  logic [WIDTH:0]   w_shl;
  logic [WIDTH:0]   w_shr;
  logic [WIDTH:0]   w_sar;
  logic [WIDTH-1:0] w_rol;
  logic [WIDTH-1:0] w_ror;
  logic [WIDTH-1:0] w_res;
  logic [WIDTH-1:0] w_final;
  logic [WIDTH-1:0] w_nz;
  logic             w_c;
  logic             w_arith;

  // Non-power-of-two widths can name an amount >= WIDTH; fold it once for rotates.
  assign w_amt = i_b[SW-1:0];
  assign w_rot = ({1'b0, w_amt} >= (SW+1)'(WIDTH)) ? w_amt - W_LO : w_amt;

  // One adder serves every arithmetic op: subtraction is x + ~y + 1.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_x   = i_a;
    w_y   = i_b;
    w_cin = 1'b0;
    case (i_op)
      OP_SUB, OP_CMP: begin w_y = ~i_b;          w_cin = 1'b1; end
      OP_DEC:         begin w_y = ~WIDTH'(1);    w_cin = 1'b1; end
      OP_INC:         begin w_y = WIDTH'(1);                   end
      OP_NEG:         begin w_x = '0; w_y = ~i_a; w_cin = 1'b1; end
      default:        ;
    endcase
  end

  assign w_sum = {1'b0, w_x} + {1'b0, w_y} + {{WIDTH{1'b0}}, w_cin};
  assign w_ovf = (w_x[MSB] == w_y[MSB]) && (w_sum[MSB] != w_x[MSB]);

  // The extra bit on each shifter catches the last bit shifted out.
  assign w_shl = {1'b0, i_a} << w_amt;
  assign w_shr = {i_a, 1'b0} >> w_amt;
  assign w_sar = $signed({i_a, 1'b0}) >>> w_amt;
  assign w_rol = (i_a << w_rot) | (i_a >> (WIDTH - int'(w_rot)));
  assign w_ror = (i_a >> w_rot) | (i_a << (WIDTH - int'(w_rot)));

  always_comb begin
    w_res   = i_a;
    w_c     = 1'b0;
    w_arith = 1'b0;
    case (i_op)
      OP_ADD, OP_SUB, OP_DEC, OP_INC, OP_NEG: begin
        w_res   = w_sum[WIDTH-1:0];
        w_c     = w_sum[WIDTH];
        w_arith = 1'b1;
      end
      OP_CMP:   begin w_res = i_a; w_c = w_sum[WIDTH]; w_arith = 1'b1; end
      OP_NOT:   w_res = ~i_a;
      OP_AND:   w_res = i_a & i_b;
      OP_OR:    w_res = i_a | i_b;
      OP_XOR:   w_res = i_a ^ i_b;
      OP_SHL:   begin w_res = w_shl[WIDTH-1:0]; w_c = w_shl[WIDTH]; end
      OP_SHR:   begin w_res = w_shr[WIDTH:1];   w_c = w_shr[0];     end
      OP_SAR:   begin w_res = w_sar[WIDTH:1];   w_c = w_sar[0];     end
      OP_ROL:   begin w_res = w_rol; w_c = (w_amt != '0) && w_rol[0];   end
      OP_ROR:   begin w_res = w_ror; w_c = (w_amt != '0) && w_ror[MSB]; end
      OP_PASSB: w_res = i_b;
      default:  ;
    endcase
  end

`ifdef ALU_SAT_EN
  logic w_sat;
  // Overflow direction follows the sign of x (both addends share it when V is set).
  assign w_sat   = w_ovf && (i_op inside {OP_ADD, OP_SUB, OP_DEC, OP_INC, OP_NEG});
  assign w_final = !w_sat ? w_res
                 : (w_x[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}});
`else
  assign w_final = w_res;
`endif

  // CMP reports the sign/zero of A-B while passing A through unchanged.
  assign w_nz     = (i_op == OP_CMP) ? w_sum[WIDTH-1:0] : w_final;
  assign o_result = w_final;

  always_comb begin
    o_flags         = '0;
    o_flags[FLAG_N] = w_nz[MSB];
    o_flags[FLAG_Z] = (w_nz == '0);
    o_flags[FLAG_C] = w_c;
    o_flags[FLAG_V] = w_arith && w_ovf;
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline: S1 holds operands+opcode, S2 holds result+flags.
// Saturating arithmetic is selected inside alu_core by the ALU_SAT_EN macro.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] ACC_IN,
  input  logic [WIDTH-1:0] BREG_IN,
  input  logic [3:0]       OP,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] ALU_OUT,
  output logic [3:0]       FLAGS
);

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  alu_op_e          r_s1_op;
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_alu_out;
  logic [3:0]       r_flags;

  logic             w_s2_load;
  logic             w_s1_load;
  logic [WIDTH-1:0] w_result;
  logic [3:0]       w_flags;

  // Ready depends only on registered state and OUT_READY, never on IN_VALID.
  assign w_s2_load = r_s1_valid && (!r_s2_valid || OUT_READY);
  assign w_s1_load = !r_s1_valid || w_s2_load;
  assign IN_READY  = w_s1_load && !RST;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_alu_out  <= '0;
      r_flags    <= '0;
    end else begin
      if (w_s1_load) r_s1_valid <= IN_VALID;
      if (w_s2_load) begin
        r_s2_valid <= 1'b1;
        r_alu_out  <= w_result;
        r_flags    <= w_flags;
      end else if (OUT_READY) begin
        r_s2_valid <= 1'b0;
      end
    end
  end

  // NOTE: operand registers carry no reset; they are only observed behind r_s1_valid.
  always_ff @(posedge CLK) begin
    if (w_s1_load && IN_VALID) begin
      r_s1_a  <= ACC_IN;
      r_s1_b  <= BREG_IN;
      r_s1_op <= alu_op_e'(OP);
    end
  end

  alu_core #(.WIDTH(WIDTH)) u_core (
    .i_a      (r_s1_a),
    .i_b      (r_s1_b),
    .i_op     (r_s1_op),
    .o_result (w_result),
    .o_flags  (w_flags)
  );

  assign OUT_VALID = r_s2_valid;
  assign ALU_OUT   = r_alu_out;
  assign FLAGS     = r_flags;

endmodule
